// File: rtl/icw_ocw_write_sequencer.sv
// Decodes CPU writes into ICW1-4 / OCW1-3 one-cycle strobes and tracks the init sequence.
// Optional output sequence_error when SEQUENCE_ERROR_FLAG_EN is defined.
module icw_ocw_write_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1_registers,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       special_mask_mode,
    output logic       single_or_cascade,
`ifdef SEQUENCE_ERROR_FLAG_EN
    output logic       sequence_error,
`endif
    output logic       icw4_needed
);

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       s_we_n;
    logic       s_cs_n;
    logic       s_a0;
    logic [7:0] s_dat;
    logic       p_we_n;
    logic       p_cs_n;
    logic       p_a0;
    logic [7:0] p_dat;

    logic       write_event;
    logic       is_icw1;
    logic [6:0] strobe;
    logic [6:0] strobe_next;
    logic       smm_next;
    logic       sngl_next;
    logic       ic4_next;

    // Two-deep input pipeline; idle values keep a write held across reset from firing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_we_n <= 1'b1;
            s_cs_n <= 1'b1;
            s_a0   <= 1'b0;
            s_dat  <= 8'h00;
            p_we_n <= 1'b1;
            p_cs_n <= 1'b1;
            p_a0   <= 1'b0;
            p_dat  <= 8'h00;
        end else begin
            s_we_n <= write_enable_n;
            s_cs_n <= chip_select_n;
            s_a0   <= address;
            s_dat  <= data_bus_in;
            p_we_n <= s_we_n;
            p_cs_n <= s_cs_n;
            p_a0   <= s_a0;
            p_dat  <= s_dat;
        end
    end

    assign write_event = !p_we_n && !p_cs_n && s_we_n;
    assign is_icw1     = !p_a0 && p_dat[4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= UNINIT;
            strobe            <= 7'b0;
            internal_data_bus <= 8'h00;
            special_mask_mode <= 1'b0;
            single_or_cascade <= 1'b0;
            icw4_needed       <= 1'b0;
        end else begin
            state             <= state_next;
            strobe            <= strobe_next;
            special_mask_mode <= smm_next;
            single_or_cascade <= sngl_next;
            icw4_needed       <= ic4_next;
            if (write_event) begin
                internal_data_bus <= p_dat;
            end
        end
    end

    always_comb begin
        state_next  = state;
        strobe_next = 7'b0;
        smm_next    = special_mask_mode;
        sngl_next   = single_or_cascade;
        ic4_next    = icw4_needed;
        if (write_event) begin
            if (is_icw1) begin
                strobe_next[0] = 1'b1;
                sngl_next      = p_dat[1];
                ic4_next       = p_dat[0];
                smm_next       = 1'b0;
                state_next     = WAIT_ICW2;
            end else begin
                case (state)
                    WAIT_ICW2: if (p_a0) begin
                        strobe_next[1] = 1'b1;
                        if (!single_or_cascade) state_next = WAIT_ICW3;
                        else if (icw4_needed)   state_next = WAIT_ICW4;
                        else                    state_next = READY;
                    end
                    WAIT_ICW3: if (p_a0) begin
                        strobe_next[2] = 1'b1;
                        state_next     = icw4_needed ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (p_a0) begin
                        strobe_next[3] = 1'b1;
                        state_next     = READY;
                    end
                    READY: begin
                        if (p_a0) begin
                            strobe_next[4] = 1'b1;
                        end else if (p_dat[3]) begin
                            strobe_next[6] = 1'b1;
                            if (p_dat[6]) smm_next = p_dat[5];
                        end else begin
                            strobe_next[5] = 1'b1;
                        end
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    assign write_initial_command_word_1             = strobe[0];
    assign write_initial_command_word_2             = strobe[1];
    assign write_initial_command_word_3             = strobe[2];
    assign write_initial_command_word_4             = strobe[3];
    assign write_operation_control_word_1_registers = strobe[4];
    assign write_operation_control_word_2           = strobe[5];
    assign write_operation_control_word_3           = strobe[6];

`ifdef SEQUENCE_ERROR_FLAG_EN
    logic ignored;
    // Any non-ICW1 write in UNINIT, or an A0=0 non-ICW1 write mid-initialisation.
    assign ignored = write_event && !is_icw1 &&
                     ((state == UNINIT) || (!p_a0 && (state != READY)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sequence_error <= 1'b0;
        end else if (write_event && is_icw1) begin
            sequence_error <= 1'b0;
        end else if (ignored) begin
            sequence_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icw_ocw_write_sequencer.sv
// Directed and randomized bench for icw_ocw_write_sequencer against a queue-based sequence model.
module tb_icw_ocw_write_sequencer;

    logic       clock;
    logic       reset_n;
    logic       chip_select_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_in;
    logic [7:0] internal_data_bus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       special_mask_mode;
    logic       single_or_cascade;
    logic       icw4_needed;
`ifdef SEQUENCE_ERROR_FLAG_EN
    logic       sequence_error;
`endif
    logic [7:0] stb_vec;

    int checks = 0;
    int errors = 0;

    // Model: ICW numbers still owed after ICW1; empty + initialised means READY.
    int         m_pending[$];
    bit         m_init;
    logic       m_sngl, m_ic4, m_smm, m_err;
    logic [7:0] m_ibus;
    logic [7:0] exp_stb;

    icw_ocw_write_sequencer dut (
        .clock                                   (clock),
        .reset_n                                 (reset_n),
        .chip_select_n                           (chip_select_n),
        .write_enable_n                          (write_enable_n),
        .address                                 (address),
        .data_bus_in                             (data_bus_in),
        .internal_data_bus                       (internal_data_bus),
        .write_initial_command_word_1            (icw1),
        .write_initial_command_word_2            (icw2),
        .write_initial_command_word_3            (icw3),
        .write_initial_command_word_4            (icw4),
        .write_operation_control_word_1_registers(ocw1),
        .write_operation_control_word_2          (ocw2),
        .write_operation_control_word_3          (ocw3),
        .special_mask_mode                       (special_mask_mode),
        .single_or_cascade                       (single_or_cascade),
`ifdef SEQUENCE_ERROR_FLAG_EN
        .sequence_error                          (sequence_error),
`endif
        .icw4_needed                             (icw4_needed)
    );

    assign stb_vec = {1'b0, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task model_reset();
        m_pending.delete();
        m_init = 0;
        m_sngl = 0;
        m_ic4  = 0;
        m_smm  = 0;
        m_err  = 0;
        m_ibus = 8'h00;
    endtask

    task model_write(input logic a0, input logic [7:0] d);
        exp_stb = 8'h00;
        m_ibus  = d;
        if (!a0 && d[4]) begin
            exp_stb = 8'h01;
            m_sngl  = d[1];
            m_ic4   = d[0];
            m_smm   = 0;
            m_err   = 0;
            m_init  = 1;
            m_pending.delete();
            m_pending.push_back(2);
            if (!d[1]) m_pending.push_back(3);
            if (d[0])  m_pending.push_back(4);
        end else if (m_init && m_pending.size() == 0) begin
            if (a0) exp_stb = 8'h10;
            else if (d[3]) begin
                exp_stb = 8'h40;
                if (d[6]) m_smm = d[5];
            end else exp_stb = 8'h20;
        end else if (a0 && m_pending.size() > 0) begin
            exp_stb = 8'h01 << (m_pending.pop_front() - 1);
        end else begin
            m_err = 1;
        end
    endtask

    task check_levels(input string tag);
        check({tag, "_ibus"}, internal_data_bus, m_ibus);
        check({tag, "_smm"}, {7'b0, special_mask_mode}, {7'b0, m_smm});
        check({tag, "_sngl"}, {7'b0, single_or_cascade}, {7'b0, m_sngl});
        check({tag, "_ic4"}, {7'b0, icw4_needed}, {7'b0, m_ic4});
`ifdef SEQUENCE_ERROR_FLAG_EN
        check({tag, "_err"}, {7'b0, sequence_error}, {7'b0, m_err});
`endif
    endtask

    // mode 0: normal write (CS# released with WR#), 1: CS# dropped before WR# rises, 2: CS# never asserted
    task write_cycle(input string tag, input logic a0, input logic [7:0] d, input int mode);
        @(negedge clock);
        chip_select_n  = (mode == 2);
        address        = a0;
        data_bus_in    = d;
        write_enable_n = 1'b0;
        repeat (2) @(negedge clock);
        if (mode == 1) begin
            chip_select_n = 1'b1;
            @(negedge clock);
        end
        write_enable_n = 1'b1;
        chip_select_n  = 1'b1;
        if (mode == 0) model_write(a0, d);
        else exp_stb = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_strobe"}, stb_vec, exp_stb);
        @(posedge clock);
        #1;
        check({tag, "_strobe_end"}, stb_vec, 8'h00);
        check_levels(tag);
    endtask

    task reset_pulse(input string tag, input bit hold_write);
        @(negedge clock);
        reset_n = 1'b0;
        if (hold_write) begin
            chip_select_n  = 1'b0;
            write_enable_n = 1'b0;
            address        = 1'b0;
            data_bus_in    = 8'h13;
        end
        #2;
        model_reset();
        check({tag, "_rst_strobe"}, stb_vec, 8'h00);
        check_levels({tag, "_rst"});
        @(negedge clock);
        reset_n        = 1'b1;
        write_enable_n = 1'b1;
        chip_select_n  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_post_strobe"}, stb_vec, 8'h00);
        check_levels({tag, "_post"});
    endtask

    initial begin
        reset_n        = 1'b1;
        chip_select_n  = 1'b1;
        write_enable_n = 1'b1;
        address        = 1'b0;
        data_bus_in    = 8'h00;
        model_reset();

        reset_pulse("init", 1'b0);

        write_cycle("uninit_a1", 1'b1, 8'hFF, 0);
        write_cycle("uninit_a0", 1'b0, 8'h20, 0);

        write_cycle("s1_icw1", 1'b0, 8'h13, 0);
        write_cycle("s1_icw2", 1'b1, 8'h20, 0);
        write_cycle("s1_icw4", 1'b1, 8'h01, 0);
        write_cycle("s1_ocw1", 1'b1, 8'hAA, 0);

        write_cycle("s2_icw1", 1'b0, 8'h10, 0);
        write_cycle("s2_icw2", 1'b1, 8'h08, 0);
        write_cycle("s2_icw3", 1'b1, 8'h04, 0);
        write_cycle("s2_ocw1", 1'b1, 8'hFE, 0);

        write_cycle("ocw3_set", 1'b0, 8'h68, 0);
        write_cycle("ocw3_keep", 1'b0, 8'h08, 0);
        write_cycle("ocw3_clr", 1'b0, 8'h48, 0);
        write_cycle("ocw2", 1'b0, 8'h20, 0);

        write_cycle("cs_high", 1'b1, 8'h55, 2);
        write_cycle("cs_drop", 1'b1, 8'h66, 1);

        write_cycle("r_icw1", 1'b0, 8'h10, 0);
        write_cycle("r_icw2", 1'b1, 8'h08, 0);
        reset_pulse("mid", 1'b1);
        write_cycle("r_after", 1'b1, 8'h04, 0);
        write_cycle("r_icw1b", 1'b0, 8'h11, 0);

        for (int i = 0; i < 300; i++) begin
            logic       a0;
            logic [7:0] d;
            int         mode;
            a0   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            mode = 0;
            if ($urandom_range(0, 5) == 0) begin
                a0   = 1'b0;
                d[4] = 1'b1;
            end else if (!a0 && $urandom_range(0, 2) != 0) begin
                d[4] = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) mode = int'($urandom_range(1, 2));
            if ($urandom_range(0, 49) == 0) reset_pulse("rnd_rst", 1'($urandom_range(0, 1)));
            write_cycle("rnd", a0, d, mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
